// File: rtl/fu_arbiter_if.sv
// Requester, response and functional-unit signals shared between the arbiter
// (slave side) and its environment of two requesters plus one FU (master side).
interface fu_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic [3:0]  req0_op;
    logic [3:0]  req1_op;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic        rsp0_ready;
    logic        rsp1_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_status;
    logic [15:0] fu_a;
    logic [15:0] fu_b;
    logic [3:0]  fu_opcode;
    logic [15:0] fu_result;
    logic [3:0]  fu_status;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_op, req1_op, rsp0_ready, rsp1_ready, fu_result, fu_status,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_result, rsp_status, fu_a, fu_b, fu_opcode
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_op, req1_op, rsp0_ready, rsp1_ready, fu_result, fu_status,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_status, fu_a, fu_b, fu_opcode
    );
endinterface

// File: rtl/fu_arbiter.sv
// Two-requester arbiter in front of one shared combinational functional unit:
// accept -> one EXEC cycle -> hold the latched response until the owner takes it.
module fu_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    fu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  status_q, status_d;

    logic        idle;
    logic        exec;
    logic        resp;
    logic        grant1;
    logic        accept;
    logic        owner_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    // Requester 1 loses a tie under fixed priority, or when it was granted last.
    assign grant1 = bus.req1_valid & ~(bus.req0_valid & (FIXED_PRIO | last_q));

    // Outputs are gated by rst so nothing is offered or driven while in reset.
    assign idle = (state_q == IDLE) & ~rst;
    assign exec = (state_q == EXEC) & ~rst;
    assign resp = (state_q == RESP) & ~rst;

    assign bus.req0_ready = idle & bus.req0_valid & ~grant1;
    assign bus.req1_ready = idle & grant1;
    assign accept         = bus.req0_ready | bus.req1_ready;

    assign bus.fu_a       = exec ? a_q  : 16'h0000;
    assign bus.fu_b       = exec ? b_q  : 16'h0000;
    assign bus.fu_opcode  = exec ? op_q : 4'h0;

    assign bus.rsp0_valid = resp & ~owner_q;
    assign bus.rsp1_valid = resp & owner_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_status = status_q;

    assign owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        status_d = status_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = grant1 ? bus.req1_a  : bus.req0_a;
                    b_d     = grant1 ? bus.req1_b  : bus.req0_b;
                    op_d    = grant1 ? bus.req1_op : bus.req0_op;
                    owner_d = grant1;
                    last_d  = grant1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = bus.fu_result;
                status_d = bus.fu_status;
                state_d  = RESP;
            end
            RESP: begin
                if (owner_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
